game_flow_ctrl: RTL and testbench

Top-level game sequencer for the DE1-SoC fighting game. It steps the design through menu, pre-round countdown, fight and game-over phases, and owns the VGA screen-select mux. It gates fighter/physics logic with `fight_enable`, runs the round clock, and decides the winner from the two health values. It sits between `menu_screen` (consumes its `start_game` pulse, drives its reset) and the fight datapath.

---
 rtl/game_flow_ctrl.sv | 175 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
// Top-level game sequencer: MENU -> COUNTDOWN -> FIGHT -> GAME_OVER -> MENU.
// Drives the VGA screen-select mux, gates the fight datapath, runs the
// pre-round countdown and the round clock, and decides the winner.
//
// Ports
//   clk             system (pixel) clock, rising edge
//   reset           synchronous active-high, returns to MENU
//   frame_tick      one-cycle pulse per video frame
//   start_game      one-cycle pulse from menu_screen
//   mode_2p         SW[0], latched when start_game is accepted
//   key_pressed     level; rising edge leaves GAME_OVER after the hold
//   p1_health       player 1 health 0..100
//   p2_health       player 2 health 0..100
//   screen_sel      0=menu 1=countdown 2=fight 3=game over
//   menu_reset      one-cycle pulse to menu_screen reset
//   round_reset     one-cycle pulse to reinitialise fighters/health
//   fight_enable    high only in FIGHT
//   countdown_val   digit shown during COUNTDOWN
//   round_time      seconds remaining in the round
//   mode_2p_latched mode captured at game start
//   winner          0=none 1=P1 2=P2 3=draw
module game_flow_ctrl #(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int COUNTDOWN_START = 3,
  parameter int ROUND_SECONDS   = 99,
  parameter int GAMEOVER_HOLD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_game,
  input  logic       mode_2p,
  input  logic       key_pressed,
  input  logic [6:0] p1_health,
  input  logic [6:0] p2_health,
  output logic [1:0] screen_sel,
  output logic       menu_reset,
  output logic       round_reset,
  output logic       fight_enable,
  output logic [2:0] countdown_val,
  output logic [6:0] round_time,
  output logic       mode_2p_latched,
  output logic [1:0] winner
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam int HW = $clog2(GAMEOVER_HOLD + 2);
  localparam logic [HW-1:0] HOLD_SECS = HW'(GAMEOVER_HOLD);

  typedef enum logic [1:0] {
    MENU      = 2'd0,
    COUNTDOWN = 2'd1,
    FIGHT     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t        state, nxt_state;
  logic [FW-1:0] frame_cnt, nxt_frame;
  logic [HW-1:0] hold_cnt, nxt_hold;
  logic          prev_key;
  logic          rst_d;       // high on the first cycle after reset releases
  logic [2:0]    nxt_cd;
  logic [6:0]    nxt_rt;
  logic          nxt_mode, nxt_rr, nxt_mr;
  logic [1:0]    nxt_win;
  logic          sec, key_edge;

  // screen_sel encodes the state directly, so it switches on the transition edge
  assign screen_sel   = state;
  assign fight_enable = (state == FIGHT);

  always_comb begin
    sec       = frame_tick && (frame_cnt == FRAME_LAST);
    key_edge  = key_pressed && !prev_key;
    nxt_state = state;
    nxt_cd    = countdown_val;
    nxt_rt    = round_time;
    nxt_mode  = mode_2p_latched;
    nxt_win   = winner;
    nxt_rr    = 1'b0;
    nxt_mr    = rst_d;
    nxt_hold  = hold_cnt;
    nxt_frame = frame_cnt;

    case (state)
      MENU: begin
        if (start_game) begin
          nxt_state = COUNTDOWN;
          nxt_mode  = mode_2p;
          nxt_cd    = 3'(COUNTDOWN_START);
          nxt_rt    = 7'(ROUND_SECONDS);
          nxt_win   = 2'd0;
          nxt_rr    = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (sec) begin
          if (countdown_val <= 3'd1) begin
            nxt_state = FIGHT;
            nxt_cd    = 3'd0;
          end else begin
            nxt_cd = countdown_val - 3'd1;
          end
        end
      end
      FIGHT: begin
        // KO outranks time-out; a transition cancels the same-edge decrement
        if (p1_health == 7'd0 && p2_health == 7'd0) begin
          nxt_win = 2'd3;  nxt_state = GAME_OVER;
        end else if (p1_health == 7'd0) begin
          nxt_win = 2'd2;  nxt_state = GAME_OVER;
        end else if (p2_health == 7'd0) begin
          nxt_win = 2'd1;  nxt_state = GAME_OVER;
        end else if (round_time == 7'd0) begin
          nxt_state = GAME_OVER;
          if (p1_health > p2_health)      nxt_win = 2'd1;
          else if (p2_health > p1_health) nxt_win = 2'd2;
          else                            nxt_win = 2'd3;
        end else if (sec) begin
          nxt_rt = round_time - 7'd1;
        end
      end
      GAME_OVER: begin
        if (hold_cnt >= HOLD_SECS) begin
          if (key_edge) begin
            nxt_state = MENU;
            nxt_mr    = 1'b1;
          end
        end else if (sec) begin
          nxt_hold = hold_cnt + 1'b1;
        end
      end
      default: nxt_state = MENU;
    endcase

    // frame/hold counters restart on every state change; that edge's tick is dropped
    if (nxt_state != state) begin
      nxt_frame = '0;
      nxt_hold  = '0;
    end else if (frame_tick) begin
      nxt_frame = sec ? '0 : frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= MENU;
      frame_cnt       <= '0;
      hold_cnt        <= '0;
      prev_key        <= 1'b0;
      rst_d           <= 1'b1;
      countdown_val   <= 3'd0;
      round_time      <= 7'd0;
      mode_2p_latched <= 1'b0;
      winner          <= 2'd0;
      round_reset     <= 1'b0;
      menu_reset      <= 1'b0;
    end else begin
      state           <= nxt_state;
      frame_cnt       <= nxt_frame;
      hold_cnt        <= nxt_hold;
      prev_key        <= key_pressed;
      rst_d           <= 1'b0;
      countdown_val   <= nxt_cd;
      round_time      <= nxt_rt;
      mode_2p_latched <= nxt_mode;
      winner          <= nxt_win;
      round_reset     <= nxt_rr;
      menu_reset      <= nxt_mr;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;
  logic       clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, start_game = 1'b0;
  logic       mode_2p = 1'b0, key_pressed = 1'b0;
  logic [6:0] p1_health = 7'd100, p2_health = 7'd100;
  logic [1:0] screen_sel, winner;
  logic       menu_reset, round_reset, fight_enable, mode_2p_latched;
  logic [2:0] countdown_val;
  logic [6:0] round_time;

  int checks = 0, errors = 0;

  localparam int SS = 0, MR = 1, RR = 2, FE = 3, CD = 4, RT = 5, ML = 6, WN = 7;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .FRAMES_PER_SEC(4), .COUNTDOWN_START(3), .ROUND_SECONDS(5), .GAMEOVER_HOLD(2)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_game(start_game),
    .mode_2p(mode_2p), .key_pressed(key_pressed),
    .p1_health(p1_health), .p2_health(p2_health),
    .screen_sel(screen_sel), .menu_reset(menu_reset), .round_reset(round_reset),
    .fight_enable(fight_enable), .countdown_val(countdown_val),
    .round_time(round_time), .mode_2p_latched(mode_2p_latched), .winner(winner)
  );

  function automatic logic [31:0] obs(int s);
    case (s)
      SS: return 32'(screen_sel);
      MR: return 32'(menu_reset);
      RR: return 32'(round_reset);
      FE: return 32'(fight_enable);
      CD: return 32'(countdown_val);
      RT: return 32'(round_time);
      ML: return 32'(mode_2p_latched);
      default: return 32'(winner);
    endcase
  endfunction

  task automatic ex(string tag, int s, int v);
    sb.push_back('{tag, s, 32'(v)});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs(e.sig) === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs(e.sig), e.val);
      end
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one frame_tick followed by 9 idle cycles
  task automatic tick(int n = 1);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc(9);
    end
  endtask

  task automatic expect_reset_vals(string tag);
    ex({tag, "_ss"}, SS, 0); ex({tag, "_fe"}, FE, 0); ex({tag, "_cd"}, CD, 0);
    ex({tag, "_rt"}, RT, 0); ex({tag, "_win"}, WN, 0); ex({tag, "_ml"}, ML, 0);
    ex({tag, "_rr"}, RR, 0); ex({tag, "_mr"}, MR, 0);
    drain();
  endtask

  task automatic to_fight(string tag, logic m);
    mode_2p = m; start_game = 1'b1;
    cyc();
    start_game = 1'b0;
    ex({tag, "_start_ss"}, SS, 1); ex({tag, "_start_rr"}, RR, 1);
    ex({tag, "_start_win"}, WN, 0); ex({tag, "_start_ml"}, ML, int'(m));
    drain();
    tick(12);
    ex({tag, "_fight_ss"}, SS, 2); ex({tag, "_fight_fe"}, FE, 1); ex({tag, "_fight_rt"}, RT, 5);
    drain();
  endtask

  task automatic exit_go(string tag);
    tick(8);
    key_pressed = 1'b1;
    cyc();
    key_pressed = 1'b0;
    ex({tag, "_exit_ss"}, SS, 0); ex({tag, "_exit_mr"}, MR, 1);
    drain();
  endtask

  initial begin
    // reset state
    cyc(2);
    expect_reset_vals("rst");
    reset = 1'b0;
    cyc();
    ex("rst_menu_reset", MR, 1); drain();
    cyc();
    ex("rst_menu_reset_drop", MR, 0); drain();

    // start in 2P mode, step through the countdown
    mode_2p = 1'b1; start_game = 1'b1;
    cyc();
    start_game = 1'b0; mode_2p = 1'b0;
    ex("st_ss", SS, 1); ex("st_rr", RR, 1); ex("st_cd", CD, 3);
    ex("st_ml", ML, 1); ex("st_rt", RT, 5); ex("st_fe", FE, 0);
    drain();
    cyc();
    ex("st_rr_drop", RR, 0); drain();
    start_game = 1'b1; cyc(); start_game = 1'b0;
    ex("cd_start_ignored_ss", SS, 1); ex("cd_start_ignored_rr", RR, 0); drain();
    tick(4); ex("cd_2", CD, 2); drain();
    tick(4); ex("cd_1", CD, 1); drain();
    tick(3); ex("cd_hold_ss", SS, 1); ex("cd_hold_fe", FE, 0); drain();
    tick();
    ex("fight_ss", SS, 2); ex("fight_fe", FE, 1); ex("fight_rt", RT, 5); ex("fight_cd", CD, 0);
    drain();
    start_game = 1'b1; cyc(); start_game = 1'b0;
    ex("fight_start_ignored", SS, 2); ex("fight_start_rr", RR, 0); drain();
    tick(4); ex("fight_rt_4", RT, 4); drain();

    // KO by P1, key already held when GAME_OVER is entered
    p1_health = 7'd40; p2_health = 7'd0; key_pressed = 1'b1;
    cyc();
    ex("ko_win", WN, 1); ex("ko_ss", SS, 3); ex("ko_fe", FE, 0); drain();
    p2_health = 7'd100;
    tick(8); cyc(5);
    ex("held_key_no_exit", SS, 3); drain();
    key_pressed = 1'b0; cyc();
    key_pressed = 1'b1; cyc();
    ex("fresh_edge_exit_ss", SS, 0); ex("fresh_edge_mr", MR, 1); ex("winner_holds", WN, 1);
    drain();
    cyc();
    ex("mr_drop", MR, 0); drain();
    key_pressed = 1'b0;
    p1_health = 7'd100;

    // double KO, then key edge inside the hold
    to_fight("dko", 1'b0);
    p1_health = 7'd0; p2_health = 7'd0;
    cyc();
    ex("dko_win", WN, 3); ex("dko_ss", SS, 3); drain();
    tick(5);
    key_pressed = 1'b1; cyc(); key_pressed = 1'b0; cyc();
    ex("hold_edge_ignored", SS, 3); drain();
    tick(3);
    key_pressed = 1'b1; cyc(); key_pressed = 1'b0;
    ex("post_hold_exit_ss", SS, 0); ex("post_hold_mr", MR, 1); drain();
    cyc();

    // time-out, P2 ahead
    p1_health = 7'd30; p2_health = 7'd70;
    to_fight("to1", 1'b1);
    tick(8); ex("to1_rt_3", RT, 3); drain();
    tick(11);
    ex("to1_rt_1", RT, 1); ex("to1_still_fight", SS, 2); drain();
    tick();
    ex("to1_rt_0", RT, 0); ex("to1_ss", SS, 3); ex("to1_win", WN, 2); drain();
    exit_go("to1");

    // time-out, draw
    p1_health = 7'd50; p2_health = 7'd50;
    to_fight("to2", 1'b0);
    tick(20);
    ex("to2_ss", SS, 3); ex("to2_win", WN, 3); drain();
    exit_go("to2");

    // KO on the tick that would zero the round clock
    p1_health = 7'd60; p2_health = 7'd20;
    to_fight("kot", 1'b0);
    tick(19);
    ex("kot_rt_1", RT, 1); drain();
    p1_health = 7'd0; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    ex("kot_ss", SS, 3); ex("kot_win", WN, 2); drain();
    exit_go("kot");

    // reset mid-fight
    p1_health = 7'd100; p2_health = 7'd100;
    to_fight("rmf", 1'b1);
    tick(8); ex("rmf_rt_3", RT, 3); drain();
    reset = 1'b1; cyc();
    expect_reset_vals("rmf");
    reset = 1'b0; cyc();
    ex("rmf_menu_reset", MR, 1); drain();
    cyc();
    ex("rmf_menu_reset_drop", MR, 0); ex("rmf_ss", SS, 0); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
